// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with per-register rename tags, write-back bypass
// on reads, and a single-level tag checkpoint for branch-mispredict recovery.
module regfile_rename_ckpt #(
    parameter int  REG_NUM  = 32,
    parameter int  DATA_W   = 32,
    parameter int  TAG_W    = 4,
    parameter int  TAG_FREE = 0,
    parameter int  NUM_WB   = 2,
    parameter int  NUM_RD   = 2,
    localparam int NAME_W   = $clog2(REG_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_WB-1:0]         wbEn,
    input  logic [NUM_WB*NAME_W-1:0]  wbName,
    input  logic [NUM_WB*TAG_W-1:0]   wbTag,
    input  logic [NUM_WB*DATA_W-1:0]  wbData,
    input  logic                      decEn,
    input  logic [NAME_W-1:0]         decName,
    input  logic [TAG_W-1:0]          decTag,
    input  logic [NUM_RD*NAME_W-1:0]  rdName,
    output logic [NUM_RD*DATA_W-1:0]  rdData,
    output logic [NUM_RD*TAG_W-1:0]   rdTag,
    input  logic                      ckptSave,
    input  logic                      ckptRestore,
    input  logic                      flush,
    output logic                      ckptValid
);
    localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

    logic [NUM_WB-1:0][NAME_W-1:0]  wb_name;
    logic [NUM_WB-1:0][TAG_W-1:0]   wb_tag;
    logic [NUM_WB-1:0][DATA_W-1:0]  wb_data;
    logic [NUM_RD-1:0][NAME_W-1:0]  rd_name;

    assign wb_name = wbName;
    assign wb_tag  = wbTag;
    assign wb_data = wbData;
    assign rd_name = rdName;

    logic [REG_NUM-1:0][DATA_W-1:0] data_q, data_d;
    logic [REG_NUM-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [REG_NUM-1:0][TAG_W-1:0]  snap_q, snap_d;
    logic                           valid_q, valid_d;

    logic [NUM_WB-1:0] wb_match;
    logic [NUM_WB-1:0] snap_hit;
    logic              restore_act;
    logic              save_act;

    assign restore_act = ckptRestore && valid_q;
    assign save_act    = ckptSave && !ckptRestore;

    // A write-back matches the live table for data/tag update; the snapshot
    // is checked independently so a producer renamed after the branch still
    // frees its pre-branch entry.
    for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_wb
        assign wb_match[gi] = wbEn[gi] && (wb_name[gi] != '0) &&
                              (wb_tag[gi] == tag_q[wb_name[gi]]);
        assign snap_hit[gi] = wbEn[gi] && (wb_name[gi] != '0) &&
                              (wb_tag[gi] == snap_q[wb_name[gi]]);
    end

    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
        logic              wb_hit;
        logic              snap_clr;
        logic              dec_hit;
        logic [DATA_W-1:0] wb_val;
        logic [TAG_W-1:0]  tag_norm;

        // Descending scan so the lowest-index matching channel wins the data.
        always_comb begin
            wb_hit   = 1'b0;
            snap_clr = 1'b0;
            wb_val   = data_q[gi];
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_name[k] == NAME_W'(gi)) begin
                    if (wb_match[k]) begin
                        wb_hit = 1'b1;
                        wb_val = wb_data[k];
                    end
                    if (snap_hit[k]) begin
                        snap_clr = 1'b1;
                    end
                end
            end
        end

        assign dec_hit  = decEn && (decName == NAME_W'(gi)) && (gi != 0);
        assign tag_norm = dec_hit ? decTag : (wb_hit ? FREE : tag_q[gi]);

        assign data_d[gi] = wb_val;

        assign tag_d[gi] = ((gi == 0) || flush) ? FREE :
                           restore_act          ? (snap_clr ? FREE : snap_q[gi]) :
                                                  tag_norm;

        assign snap_d[gi] = flush                  ? FREE :
                            restore_act            ? snap_q[gi] :
                            save_act               ? tag_norm :
                            (valid_q && snap_clr)  ? FREE :
                                                     snap_q[gi];
    end

    assign valid_d = flush       ? 1'b0 :
                     restore_act ? 1'b0 :
                     save_act    ? 1'b1 :
                                   valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            tag_q   <= {REG_NUM{FREE}};
            snap_q  <= {REG_NUM{FREE}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [DATA_W-1:0] rd_val;
        logic [TAG_W-1:0]  rd_tag_val;

        always_comb begin
            rd_val     = data_q[rd_name[gi]];
            rd_tag_val = tag_q[rd_name[gi]];
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_match[k] && (wb_name[k] == rd_name[gi])) begin
                    rd_val     = wb_data[k];
                    rd_tag_val = FREE;
                end
            end
            if (rst || (rd_name[gi] == '0)) begin
                rd_val     = '0;
                rd_tag_val = FREE;
            end
        end

        assign rdData[gi*DATA_W +: DATA_W] = rd_val;
        assign rdTag[gi*TAG_W +: TAG_W]    = rd_tag_val;
    end

    assign ckptValid = valid_q;

endmodule
